// File: rtl/bus_handshake_pkg.sv
// Shared types and the round-robin pick helper for the bus handshake arbiter.
// The helper works on a 16-wide request vector so one function serves every legal N.
package bus_handshake_pkg;

    localparam int N_DEF     = 4;
    localparam int WIDTH_DEF = 32;
    localparam int RR_MAX    = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit at or above ptr, wrapping modulo n; bits at n and above are ignored.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [3:0]        ptr,
                                         input int                n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && !r.found && req[j]) begin
                r.found = 1'b1;
                r.idx   = 4'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_handshake_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first requester at or above the pointer,
// wrapping modulo N.
module rr_arbiter
    import bus_handshake_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int IDW = $clog2(N)
) (
    input  logic [IDW-1:0] i_ptr,
    input  logic [N-1:0]   i_req,
    output logic [IDW-1:0] o_idx,
    output logic           o_found
);

    logic [RR_MAX-1:0] w_req;
    logic [3:0]        w_ptr;
    rr_pick_t          w_pick;

    always_comb begin
        w_req          = '0;
        w_req[N-1:0]   = i_req;
        w_ptr          = '0;
        w_ptr[IDW-1:0] = i_ptr;
        w_pick         = rr_pick(w_req, w_ptr, N);
    end

    assign o_idx   = w_pick.idx[IDW-1:0];
    assign o_found = w_pick.found;

endmodule

// File: rtl/bus_handshake_arbiter.sv
// N-to-1 round-robin arbiter onto one valid/ready channel with a registered
// output stage and packet lock from first beat to the beat carrying last.
module bus_handshake_arbiter
    import bus_handshake_pkg::*;
#(
    parameter  int N     = N_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int IDW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       valid_dnt,
    input  logic [N*WIDTH-1:0] data_dnt,
    input  logic [N-1:0]       last_dnt,
    output logic [N-1:0]       ready_dnt,
    output logic               valid_src,
    output logic [WIDTH-1:0]   data_src,
    output logic               last_src,
    output logic [IDW-1:0]     id_src,
    input  logic               ready_src
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_lock_id;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic [IDW-1:0]   r_id;

    logic [IDW-1:0]   w_arb_idx;
    logic             w_arb_found;
    logic [IDW-1:0]   w_gnt;
    logic             w_gnt_vld;
    logic [IDW-1:0]   w_gnt_inc;
    logic             w_load;
    logic             w_acc;
    logic             w_acc_last;
    logic [WIDTH-1:0] w_data_sel;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_arbiter (
        .i_ptr   (r_ptr),
        .i_req   (valid_dnt),
        .o_idx   (w_arb_idx),
        .o_found (w_arb_found)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign w_load = ready_src | ~r_valid;

    always_comb begin
        w_gnt     = w_arb_idx;
        w_gnt_vld = w_arb_found;
        if (r_state == LOCKED) begin
            w_gnt     = r_lock_id;
            w_gnt_vld = 1'b1;
        end
    end

    // In IDLE a found grant already implies the requester is valid.
    always_comb begin
        ready_dnt = '0;
        if (!rst && w_load && w_gnt_vld) begin
            ready_dnt[w_gnt] = 1'b1;
        end
    end

    assign w_acc      = valid_dnt[w_gnt] & ready_dnt[w_gnt];
    assign w_acc_last = last_dnt[w_gnt];
    assign w_data_sel = data_dnt[w_gnt*WIDTH +: WIDTH];
    assign w_gnt_inc  = (w_gnt == IDW'(N-1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_acc && !w_acc_last) w_state_nxt = LOCKED;
            LOCKED:  if (w_acc &&  w_acc_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // While locked w_gnt equals r_lock_id, so the pointer lands on lock_id+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_lock_id <= '0;
        end else if (w_acc) begin
            if (w_acc_last) begin
                r_ptr <= w_gnt_inc;
            end else begin
                r_lock_id <= w_gnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_id    <= '0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_data  <= w_data_sel;
            r_last  <= w_acc_last;
            r_id    <= w_gnt;
        end else if (w_load) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_src = r_valid;
    assign data_src  = r_data;
    assign last_src  = r_last;
    assign id_src    = r_id;

endmodule

// File: tb/tb_bus_handshake_arbiter.sv
// Randomized and directed bench for bus_handshake_arbiter against a
// transaction-level reference model of the arbitration rules.
module tb_bus_handshake_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     valid_dnt = '0;
    logic [N*W-1:0]   data_dnt = '0;
    logic [N-1:0]     last_dnt = '0;
    logic [N-1:0]     ready_dnt;
    logic             valid_src;
    logic [W-1:0]     data_src;
    logic             last_src;
    logic [1:0]       id_src;
    logic             ready_src = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    // requester scripts: beats left in current packet, payload, hold-off, auto reload
    int          src_len  [N];
    logic [W-1:0] src_data[N];
    bit          src_hold [N];
    bit          src_auto [N];

    // reference model
    bit          m_valid;
    logic [W-1:0] m_data;
    bit          m_last;
    int          m_id;
    bit          m_locked;
    int          m_lock;
    int          m_ptr;
    logic [N-1:0] e_ready;
    bit          m_acc;
    int          m_g;

    bus_handshake_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_dnt (valid_dnt),
        .data_dnt  (data_dnt),
        .last_dnt  (last_dnt),
        .ready_dnt (ready_dnt),
        .valid_src (valid_src),
        .data_src  (data_src),
        .last_src  (last_src),
        .id_src    (id_src),
        .ready_src (ready_src)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            valid_dnt[i]       = (src_len[i] > 0) && !src_hold[i];
            last_dnt[i]        = (src_len[i] == 1);
            data_dnt[i*W +: W] = src_data[i];
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_last = 0; m_id = 0;
        m_locked = 0; m_lock = 0; m_ptr = 0;
    endtask

    task automatic model_comb();
        bit found;
        int j;
        found = 0;
        m_g   = 0;
        if (m_locked) begin
            found = 1;
            m_g   = m_lock;
        end else begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && valid_dnt[j]) begin
                    found = 1;
                    m_g   = j;
                end
            end
        end
        e_ready = '0;
        if ((ready_src || !m_valid) && found) e_ready[m_g] = 1'b1;
        m_acc = found && e_ready[m_g] && valid_dnt[m_g];
    endtask

    task automatic model_commit(input logic [W-1:0] d, input bit l);
        if (m_acc) begin
            m_valid = 1; m_data = d; m_last = l; m_id = m_g;
            if (l) begin
                m_locked = 0;
                m_ptr    = (m_g + 1) % N;
            end else begin
                m_locked = 1;
                m_lock   = m_g;
            end
        end else if (ready_src || !m_valid) begin
            m_valid = 0;
        end
    endtask

    task automatic tick();
        logic [W-1:0] d;
        bit l;
        drive_src();
        #1;
        model_comb();
        check_val("ready_dnt", 64'(ready_dnt), 64'(e_ready));
        check_val("valid_src", 64'(valid_src), 64'(m_valid));
        check_val("data_src",  64'(data_src),  64'(m_data));
        check_val("last_src",  64'(last_src),  64'(m_last));
        check_val("id_src",    64'(id_src),    64'(m_id));
        d = src_data[m_g];
        l = (src_len[m_g] == 1);
        @(posedge clk);
        #1;
        model_commit(d, l);
        if (m_acc) begin
            src_len[m_g]--;
            src_data[m_g] = $urandom;
            if (src_len[m_g] == 0 && src_auto[m_g]) src_len[m_g] = 1;
        end
    endtask

    task automatic src_clear();
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 0;
            src_hold[i] = 0;
            src_auto[i] = 0;
            src_data[i] = $urandom;
        end
    endtask

    // Asserted away from the clock edge; outputs and ready must collapse at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_valid_src", 64'(valid_src), 64'd0);
        check_val("rst_ready_dnt", 64'(ready_dnt), 64'd0);
        check_val("rst_data_src",  64'(data_src),  64'd0);
        check_val("rst_id_src",    64'(id_src),    64'd0);
        check_val("rst_last_src",  64'(last_src),  64'd0);
        model_reset();
        src_clear();
        drive_src();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        src_clear();
        model_reset();
        drive_src();
        #2;
        do_reset();

        // single requester
        src_data[2] = 32'hA5A5_0001;
        src_len[2]  = 1;
        tick();
        check_val("single_valid", 64'(valid_src), 64'd1);
        check_val("single_data",  64'(data_src),  64'hA5A5_0001);
        check_val("single_id",    64'(id_src),    64'd2);
        check_val("single_last",  64'(last_src),  64'd1);
        src_len[0] = 1;
        src_len[3] = 1;
        drive_src();
        #1;
        check_val("single_ptr3", 64'(ready_dnt), 64'b1000);
        tick();
        tick();
        do_reset();

        // round robin
        for (int i = 0; i < N; i++) begin
            src_len[i]  = 1;
            src_auto[i] = 1;
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check_val("rr_valid", 64'(valid_src), 64'd1);
            check_val("rr_id",    64'(id_src),    64'(k % N));
        end
        do_reset();

        // packet lock
        src_len[0] = 1;
        tick();
        src_len[0] = 1;
        src_len[1] = 3;
        src_len[3] = 1;
        begin
            int exp_ids[5] = '{1, 1, 1, 3, 0};
            for (int k = 0; k < 5; k++) begin
                tick();
                check_val("lock_id", 64'(id_src), 64'(exp_ids[k]));
            end
        end
        tick();
        do_reset();

        // backpressure
        src_len[1] = 1;
        src_len[2] = 1;
        tick();
        ready_src = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("bp_valid", 64'(valid_src), 64'd1);
            check_val("bp_id",    64'(id_src),    64'd1);
            check_val("bp_ready", 64'(ready_dnt), 64'd0);
        end
        ready_src = 1'b1;
        tick();
        check_val("bp_release_id", 64'(id_src), 64'd2);
        tick();
        do_reset();

        // locked bubble
        src_len[2] = 2;
        tick();
        src_hold[2] = 1;
        src_len[0]  = 1;
        for (int k = 0; k < 3; k++) begin
            drive_src();
            #1;
            check_val("bubble_ready0", 64'(ready_dnt[0]), 64'd0);
            tick();
            check_val("bubble_valid", 64'(valid_src), 64'd0);
        end
        src_hold[2] = 0;
        tick();
        check_val("bubble_resume_id",   64'(id_src),   64'd2);
        check_val("bubble_resume_last", 64'(last_src), 64'd1);
        tick();
        check_val("bubble_next_id", 64'(id_src), 64'd0);

        // async reset mid-packet
        src_len[1] = 3;
        tick();
        tick();
        do_reset();
        src_len[3] = 1;
        tick();
        check_val("post_rst_valid", 64'(valid_src), 64'd1);
        check_val("post_rst_id",    64'(id_src),    64'd3);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 1000 == 999) do_reset();
            ready_src = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                if (src_len[i] == 0 && $urandom_range(2) == 0) src_len[i] = $urandom_range(1, 4);
                if (src_hold[i] && $urandom_range(1) == 0) src_hold[i] = 0;
            end
            tick();
            if (m_acc && src_len[m_g] != 0 && $urandom_range(3) == 0) src_hold[m_g] = 1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_handshake_arbiter.md
Name: bus_handshake_arbiter

Overview:
- N-to-1 round-robin arbiter sharing one valid/ready handshake channel between N requesters.
- Registered output stage: one beat per cycle, one cycle latency.
- Packet lock: once a requester's first beat is accepted, the grant holds until its beat with last set.
- Sits between multiple producers and one bus_handshake-style consumer. Output carries the winning requester's index.

Parameters:
- N, 4, number of requesters (2..16).
- WIDTH, 32, data width per requester.
- IDW, $clog2(N), width of the requester index (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_dnt  input  N  per-requester valid.
- data_dnt  input  N*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- last_dnt  input  N  per-requester end-of-packet flag.
- ready_dnt  output  N  per-requester ready (one-hot or zero).
- valid_src  output  1  output valid (registered).
- data_src  output  WIDTH  output data (registered).
- last_src  output  1  output last (registered).
- id_src  output  IDW  index of the requester that produced the current output beat (registered).
- ready_src  input  1  downstream ready.

Behaviour:
- Reset (rst high, async): valid_src=0, data_src=0, last_src=0, id_src=0, rr pointer=0, state=IDLE, lock_id=0. ready_dnt=0 while rst is high.
- Load enable: load = ready_src | ~valid_src, a combinational bubble collapse.
- Grant selection, IDLE:
  - gnt = first i with valid_dnt[i]=1, searching from pointer upward and wrapping modulo N.
  - No valid requester: no grant.
- Grant selection, LOCKED: gnt = lock_id regardless of other valids.
- ready_dnt[i] = load & (gnt==i), and in IDLE additionally requires valid_dnt[i]. At most one bit is set.
- Accept: a beat is accepted when valid_dnt[g] & ready_dnt[g]. On the next edge:
  - valid_src=1, data_src=data_dnt[g], last_src=last_dnt[g], id_src=g.
- Drain: if load=1 and nothing is accepted, then valid_src=0 on the next edge. data_src, last_src and id_src hold.
- Stall: if ready_src=0 and valid_src=1, all outputs hold and ready_dnt=0.
- State machine, IDLE:
  - Accept with last=0 -> LOCKED, lock_id=g.
  - Accept with last=1 -> stay IDLE, pointer=(g+1) mod N.
- State machine, LOCKED:
  - Accept with last=1 -> IDLE, pointer=(lock_id+1) mod N.
  - Any other case stays LOCKED.
- LOCKED and valid_dnt[lock_id]=0: the channel idles (bubble). Other requesters get no grant, and there is no timeout.
- Wrap-around: the pointer advances from N-1 to 0.
- Simultaneous events: an output beat drained and a new beat loaded in the same cycle gives full throughput, 1 beat/cycle.
- Fairness: with all N requesters sending single-beat packets continuously, the grant order is 0,1,..,N-1,0. Worst-case wait is N-1 packets.
- Reset mid-packet: the lock is released, the pointer returns to 0, and the output beat is dropped. Upstream must restart the packet.
- Requester rules: a requester must hold valid and data stable until accepted. The block does not check this.

Decomposition:
- Package bus_handshake_pkg:
  - State enum (IDLE, LOCKED).
  - Function rr_pick(req, ptr) returning the index plus a found flag.
  - Default constants WIDTH_DEF=32, N_DEF=4.
- Sub-module rr_arbiter (N, pointer in, request vector in, index and found out) is purely combinational. The top module holds the FSM, pointer and output register.

Test Plan:
- Single requester: req 2 sends one beat 0xA5A5_0001 with last=1, ready_src=1 -> valid_src rises the next cycle with data_src=0xA5A5_0001 and id_src=2; the pointer becomes 3.
- Round robin: all 4 requesters send continuous single-beat packets, ready_src=1 -> id_src sequence is 0,1,2,3,0,1 with no bubbles.
- Packet lock: req 1 sends a 3-beat packet (last on beat 3) while req 0 and req 3 are valid -> 3 consecutive beats with id_src=1, then id_src=3 (pointer 2 has no request), then 0.
- Backpressure: ready_src held low for 5 cycles with valid_src=1 -> outputs stable and ready_dnt=0 throughout; the first beat is released on the cycle ready_src returns high.
- Locked bubble: req 2 drops valid mid-packet for 3 cycles while req 0 is valid -> ready_dnt[0] stays 0, valid_src goes 0 after drain, and req 2 resumes with id_src=2.
- Async reset: assert rst mid-packet between clock edges -> valid_src=0 and ready_dnt=0 immediately; after release, req 3 alone gets a grant and id_src=3.
